// File: rtl/rv32i_defs_pkg.sv
// Shared RV32I register-file constants: data width, register count and index width.
package rv32i_defs;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REG_AW = $clog2(NREG);
    localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on allocation,
// cleared on write-back, wiped on flush. Bit 0 (x0) is never set.
module rf_scoreboard #(
    parameter int NREG = rv32i_defs::NREG,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;

    // NOTE: sequential state uses non-blocking assignments; when two of them hit
    // the same bit in one block, the later statement wins, which encodes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else if (flush) begin
            busy_q <= '0;
        end else begin
            if (clr_en && clr_addr != '0) busy_q[clr_addr] <= 1'b0;
            // Placed after the clear so a newer producer wins a same-cycle collision.
            if (set_en && set_addr != '0) busy_q[set_addr] <= 1'b1;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-read-port register file with integrated busy-bit scoreboard.
// Writes land on posedge; all read ports sample data and busy flags on negedge.
module reg_file_mp_sb #(
    parameter int XLEN = rv32i_defs::XLEN,
    parameter int NREG = rv32i_defs::NREG,
    parameter int NRP  = 2,
    localparam int AW = $clog2(NREG)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cu_rdwrite,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_in,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    output logic [NRP-1:0]      rs_busy,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy;

    // NOTE: the storage array is reset in full so no read can ever return X;
    // this costs a reset net on every flop but removes any x0/uninitialised corner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (cu_rdwrite && rd_addr != '0) begin
            rf[rd_addr] <= rd_in;
        end
    end

    rf_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (alloc_en),
        .set_addr (alloc_addr),
        .clr_en   (cu_rdwrite),
        .clr_addr (rd_addr),
        .flush    (flush),
        .busy_vec (busy)
    );

    assign busy_vec = busy;

    // Negedge sampling gives write-then-read in the same cycle without a bypass mux.
    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_q;
        logic            busy_q;

        assign addr = rs_addr[p*AW +: AW];

        always_ff @(negedge clock or posedge reset) begin
            if (reset) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                data_q <= (addr == '0) ? '0 : rf[addr];
                busy_q <= busy[addr];
            end
        end

        assign rs_data[p*XLEN +: XLEN] = data_q;
        assign rs_busy[p] = busy_q;
    end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Directed bench for reg_file_mp_sb: default 2-port RV32I file plus a 4-port 16x16 variant.
module tb_reg_file_mp_sb;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // Default instance: XLEN=32, NREG=32, NRP=2
    logic        cu_rdwrite, alloc_en, flush;
    logic [4:0]  rd_addr, alloc_addr;
    logic [31:0] rd_in;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic [31:0] busy_vec;

    // Wide-port instance: XLEN=16, NREG=16, NRP=4
    logic        p_rdwrite, p_alloc_en, p_flush;
    logic [3:0]  p_rd_addr, p_alloc_addr;
    logic [15:0] p_rd_in;
    logic [15:0] p_rs_addr;
    logic [63:0] p_rs_data;
    logic [3:0]  p_rs_busy;
    logic [15:0] p_busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_mp_sb u_dut (
        .clock      (clock),
        .reset      (reset),
        .cu_rdwrite (cu_rdwrite),
        .rd_addr    (rd_addr),
        .rd_in      (rd_in),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    reg_file_mp_sb #(.XLEN(16), .NREG(16), .NRP(4)) u_dut_p4 (
        .clock      (clock),
        .reset      (reset),
        .cu_rdwrite (p_rdwrite),
        .rd_addr    (p_rd_addr),
        .rd_in      (p_rd_in),
        .rs_addr    (p_rs_addr),
        .rs_data    (p_rs_data),
        .rs_busy    (p_rs_busy),
        .alloc_en   (p_alloc_en),
        .alloc_addr (p_alloc_addr),
        .flush      (p_flush),
        .busy_vec   (p_busy_vec)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cu_rdwrite = 1'b0; alloc_en = 1'b0; flush = 1'b0;
        p_rdwrite = 1'b0; p_alloc_en = 1'b0; p_flush = 1'b0;
    endtask

    // Inputs are set just after a negedge; one step covers the posedge update
    // and the following negedge read, then samples 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
        @(negedge clock);
        #1;
    endtask

    initial begin
        idle();
        rd_addr = '0; alloc_addr = '0; rd_in = '0; rs_addr = '0;
        p_rd_addr = '0; p_alloc_addr = '0; p_rd_in = '0; p_rs_addr = '0;

        #3;
        check("reset_rs_data", rs_data, 64'd0);
        check("reset_rs_busy", {62'd0, rs_busy}, 64'd0);
        check("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
        @(negedge clock); #1;
        reset = 1'b0;

        // Write x5 and allocate x8 so outputs are non-zero before the mid-cycle reset.
        cu_rdwrite = 1'b1; rd_addr = 5'd5; rd_in = 32'hDEADBEEF;
        alloc_en = 1'b1; alloc_addr = 5'd8; rs_addr = {5'd8, 5'd5};
        step(); idle();
        check("pre_reset_x5", rs_data, {32'h0, 32'hDEADBEEF});
        check("pre_reset_busy", {32'd0, busy_vec}, 64'h100);
        check("pre_reset_rs_busy", {62'd0, rs_busy}, 64'd2);
        #2; reset = 1'b1; #1;
        check("midreset_rs_data", rs_data, 64'd0);
        check("midreset_rs_busy", {62'd0, rs_busy}, 64'd0);
        check("midreset_busy_vec", {32'd0, busy_vec}, 64'd0);
        @(negedge clock); #1;
        reset = 1'b0;
        rs_addr = {5'd5, 5'd5};
        step();
        check("post_reset_x5", rs_data, 64'd0);

        // Successive writes; second write read back at the same cycle's negedge.
        cu_rdwrite = 1'b1; rd_addr = 5'd1; rd_in = 32'h12345678;
        step();
        cu_rdwrite = 1'b1; rd_addr = 5'd2; rd_in = 32'hCAFEF00D; rs_addr = {5'd2, 5'd1};
        step(); idle();
        check("read_x1_x2", rs_data, {32'hCAFEF00D, 32'h12345678});

        cu_rdwrite = 1'b1; rd_addr = 5'd3; rd_in = 32'd7; rs_addr = {5'd3, 5'd3};
        step(); idle();
        check("wr_then_rd_x3_dup", rs_data, {32'd7, 32'd7});

        // x0 is never written or allocated.
        cu_rdwrite = 1'b1; rd_addr = 5'd0; rd_in = 32'hFFFFFFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0; rs_addr = {5'd1, 5'd0};
        step(); idle();
        check("x0_read", rs_data, {32'h12345678, 32'h0});
        check("x0_busy_vec", {32'd0, busy_vec}, 64'd0);
        check("x0_rs_busy", {62'd0, rs_busy}, 64'd0);

        // Allocate x4, then write it back.
        alloc_en = 1'b1; alloc_addr = 5'd4; rs_addr = {5'd4, 5'd4};
        step(); idle();
        check("alloc_x4_busy_vec", {32'd0, busy_vec}, 64'h10);
        check("alloc_x4_rs_busy", {62'd0, rs_busy}, 64'd3);
        cu_rdwrite = 1'b1; rd_addr = 5'd4; rd_in = 32'd9;
        step(); idle();
        check("wb_x4_busy_vec", {32'd0, busy_vec}, 64'd0);
        check("wb_x4_rs_busy", {62'd0, rs_busy}, 64'd0);
        check("wb_x4_rs_data", rs_data, {32'd9, 32'd9});

        // Same-edge alloc and write-back of x6: alloc wins, data still lands.
        alloc_en = 1'b1; alloc_addr = 5'd6;
        cu_rdwrite = 1'b1; rd_addr = 5'd6; rd_in = 32'd3; rs_addr = {5'd6, 5'd6};
        step(); idle();
        check("collide_x6_busy_vec", {32'd0, busy_vec}, 64'h40);
        check("collide_x6_rs_busy", {62'd0, rs_busy}, 64'd3);
        check("collide_x6_rs_data", rs_data, {32'd3, 32'd3});

        // Re-alloc of busy x6 keeps it set; add x9 too.
        alloc_en = 1'b1; alloc_addr = 5'd9; rs_addr = {5'd9, 5'd6};
        step();
        alloc_en = 1'b1; alloc_addr = 5'd6;
        step(); idle();
        check("realloc_busy_vec", {32'd0, busy_vec}, 64'h240);

        // Flush beats a same-edge alloc; same-edge write-back still updates rf.
        alloc_en = 1'b1; alloc_addr = 5'd7; flush = 1'b1;
        cu_rdwrite = 1'b1; rd_addr = 5'd9; rd_in = 32'h55AA55AA; rs_addr = {5'd7, 5'd9};
        step(); idle();
        check("flush_busy_vec", {32'd0, busy_vec}, 64'd0);
        check("flush_rs_busy", {62'd0, rs_busy}, 64'd0);
        check("flush_wb_x9", rs_data, {32'd0, 32'h55AA55AA});

        // Wide-port variant: 4-bit addresses, 16-bit data.
        p_rdwrite = 1'b1; p_rd_addr = 4'd15; p_rd_in = 16'hA5A5;
        p_rs_addr = {4'd15, 4'd15, 4'd15, 4'd15};
        step();
        check("p4_all_x15", p_rs_data, 64'hA5A5_A5A5_A5A5_A5A5);
        p_rdwrite = 1'b1; p_rd_addr = 4'd14; p_rd_in = 16'h1234;
        p_alloc_en = 1'b1; p_alloc_addr = 4'd9;
        p_rs_addr = {4'd0, 4'd9, 4'd14, 4'd15};
        step(); idle();
        check("p4_decode", p_rs_data, 64'h0000_0000_1234_A5A5);
        check("p4_busy_vec", {48'd0, p_busy_vec}, 64'h0200);
        check("p4_rs_busy", {60'd0, p_rs_busy}, 64'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
